// File: rtl/iir_out_decimator.sv
// -----------------------------------------------------------------------------
// iir_out_decimator
//
// Downstream stage of the 4-bit IIR filter. Accumulates each block of
// 2**SHIFT accepted samples and emits their signed average as one 4-bit
// result, one cycle after the block's last sample. The result sits in an
// output register guarded by out_valid/out_ready. The filter is never
// back-pressured: a new result overwrites an unconsumed one, and each
// overwrite is recorded in a saturating 8-bit drop counter.
//
// Build option:
//   IIR_DECIM_ROUND_EN  defined   -> average rounds half toward +inf
//                       undefined -> average is floor (arithmetic shift)
//
// Parameters:
//   SHIFT  log2 of the decimation factor (1..4)
//   ACC_W  accumulator width, derived as 4+SHIFT (do not override)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   in_data carries a filter sample this cycle
//   in_data    signed 4-bit filter sample
//   in_ready   high from the first edge after reset release
//   out_valid  out_data holds an unconsumed result
//   out_data   signed 4-bit block average
//   out_ready  consumer takes out_data when out_valid & out_ready
//   drop_cnt   saturating count of overwritten results
// -----------------------------------------------------------------------------
module iir_out_decimator #(
    parameter int SHIFT = 2,
    parameter int ACC_W = 4 + SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic signed [3:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic signed [3:0] out_data,
    input  logic              out_ready,
    output logic [7:0]        drop_cnt
);

    localparam logic [SHIFT-1:0] LAST_IDX = '1;

    // Block average of an accumulated sum. ACC_W = 4+SHIFT holds any sum of
    // 2**SHIFT 4-bit samples, plus the rounding bias, so neither the add nor
    // the truncation to 4 bits can overflow.
`ifdef IIR_DECIM_ROUND_EN
    localparam int HALF = 1 << (SHIFT - 1);

    function automatic logic signed [3:0] block_avg(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] biased;
        biased = sum + ACC_W'(HALF);
        return 4'(biased >>> SHIFT);
    endfunction
`else
    function automatic logic signed [3:0] block_avg(input logic signed [ACC_W-1:0] sum);
        return 4'(sum >>> SHIFT);
    endfunction
`endif

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SHIFT-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [3:0]       out_data_q, out_data_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;
    logic                    in_ready_q, in_ready_d;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    complete;

    assign in_ext   = {{SHIFT{in_data[3]}}, in_data};
    assign sum      = acc_q + in_ext;
    assign complete = in_valid && (cnt_q == LAST_IDX);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        drop_cnt_d  = drop_cnt_q;
        in_ready_d  = 1'b1;

        if (complete) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = block_avg(sum);
            out_valid_d = 1'b1;
            // Overwriting a result nobody took this edge counts as a drop.
            if (out_valid_q && !out_ready && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else begin
            if (in_valid) begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_cnt_q  <= drop_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_iir_out_decimator.sv
// -----------------------------------------------------------------------------
// Testbench for iir_out_decimator (SHIFT=2, i.e. blocks of 4 samples).
// Directed steps from the block's intended use, then random traffic and a
// long overrun, all compared against a sample-list reference model.
// Honours IIR_DECIM_ROUND_EN for the expected averages.
// -----------------------------------------------------------------------------
module tb_iir_out_decimator;

    localparam int SHIFT = 2;
    localparam int DECIM = 1 << SHIFT;
`ifdef IIR_DECIM_ROUND_EN
    localparam int BIAS   = DECIM / 2;
    localparam int E_RAMP = 3;
    localparam int E_NEG  = -1;
`else
    localparam int BIAS   = 0;
    localparam int E_RAMP = 2;
    localparam int E_NEG  = -2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [3:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic signed [3:0] out_data;
    logic              out_ready = 1'b0;
    logic [7:0]        drop_cnt;

    iir_out_decimator #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the samples of the current block, the held result,
    // its valid flag, the drop count and in_ready.
    int blk[$];
    bit m_valid;
    int m_data;
    int m_drop;
    bit m_ready;

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        blk.delete();
        m_valid = 1'b0;
        m_data  = 0;
        m_drop  = 0;
        m_ready = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [3:0] d, input logic r);
        bit done;
        int s;
        int total;
        done = 1'b0;
        m_ready = 1'b1;
        if (v) begin
            s = int'($signed(d));
            blk.push_back(s);
            if (blk.size() == DECIM) begin
                total = 0;
                foreach (blk[i]) total += blk[i];
                if (m_valid && !r && m_drop < 255) m_drop++;
                m_valid = 1'b1;
                m_data  = floor_div(total + BIAS, DECIM);
                blk.delete();
                done = 1'b1;
            end
        end
        if (!done && m_valid && r) m_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input int exp);
        logic [3:0] e;
        e = exp[3:0];
        check(tag, {4'h0, obs}, {4'h0, e});
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e;
        e = m_data[3:0];
        check({tag, "_out_valid"}, {7'b0, out_valid}, {7'b0, m_valid});
        check({tag, "_out_data"},  {4'h0, out_data},  {4'h0, e});
        check({tag, "_drop_cnt"},  drop_cnt,          8'(m_drop));
        check({tag, "_in_ready"},  {7'b0, in_ready},  {7'b0, m_ready});
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        check_all("step");
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic apply_reset();
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        model_reset();
        check_all("in_reset");
        @(posedge clk);
        #1;
        check_all("in_reset_edge");
        rst = 1'b1;
        #1;
        check_all("released");
        step(1'b0, 4'h0, 1'b0);
        check("ready_after_release", {7'b0, in_ready}, 8'd1);
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Ramp 1,2,3,4 with continuous valid and a ready consumer.
        step(1'b1, 4'h1, 1'b1);
        step(1'b1, 4'h2, 1'b1);
        step(1'b1, 4'h3, 1'b1);
        check("ramp_not_yet", {7'b0, out_valid}, 8'd0);
        step(1'b1, 4'h4, 1'b1);
        check("ramp_valid", {7'b0, out_valid}, 8'd1);
        check4("ramp_data", out_data, E_RAMP);
        step(1'b0, 4'h0, 1'b1);
        check("ramp_pulse_end", {7'b0, out_valid}, 8'd0);
        check("ramp_no_drop", drop_cnt, 8'd0);

        // Negative block -1,-1,-1,-2.
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hE, 1'b1);
        check4("neg_data", out_data, E_NEG);

        // Extremes.
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'h7, 1'b1);
        check4("max_data", out_data, 7);
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'h8, 1'b1);
        check4("min_data", out_data, -8);
        step(1'b0, 4'h0, 1'b1);

        // Stalled consumer: second result overwrites the first.
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'h4, 1'b0);
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'hC, 1'b0);
        check("ovr_valid", {7'b0, out_valid}, 8'd1);
        check4("ovr_data", out_data, -4);
        check("ovr_drop", drop_cnt, 8'd1);
        step(1'b0, 4'h0, 1'b1);
        check("ovr_consumed", {7'b0, out_valid}, 8'd0);

        // Reset in the middle of a block discards the partial sum.
        step(1'b1, 4'h5, 1'b1);
        step(1'b1, 4'h5, 1'b1);
        apply_reset();
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'h2, 1'b1);
        check4("midrst_data", out_data, 2);
        check("midrst_drop", drop_cnt, 8'd0);

        // Gapped input: 3 with valid toggling.
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h3, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h3, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h3, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        check("gap_not_yet", {7'b0, out_valid}, 8'd0);
        step(1'b1, 4'h3, 1'b1);
        check("gap_valid", {7'b0, out_valid}, 8'd1);
        check4("gap_data", out_data, 3);

        // Completion coincident with a consumed pending result: no drop.
        step(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < DECIM; i++) step(1'b1, 4'h1, 1'b0);
        for (int i = 0; i < DECIM - 1; i++) step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h6, 1'b1);
        check("coinc_valid", {7'b0, out_valid}, 8'd1);
        check4("coinc_data", out_data, 6);
        check("coinc_no_drop", drop_cnt, 8'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Long overrun drives the drop counter into saturation.
        for (int i = 0; i < 1040; i++) step(1'b1, 4'($urandom), 1'b0);
        check("drop_saturated", drop_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_out_decimator.md
Name: iir_out_decimator

Overview:
- Downstream stage of the 4-bit IIR filter.
- Accepts the filter's signed 4-bit output stream and averages each block of 2**SHIFT samples into one signed 4-bit result.
- Presents each result to the consumer with a valid/ready handshake.
- Never stalls the filter; if the consumer is slow, unconsumed results are overwritten and counted.

Parameters:
- SHIFT, 2, log2 of the decimation factor; DECIM = 2**SHIFT; legal range 1..4.
- ACC_W, 4+SHIFT, accumulator width in bits (derived, do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a filter sample this cycle.
- in_data  input  4  signed two's-complement sample (filter y).
- in_ready  output  1  tied high after reset; the block never back-pressures the filter.
- out_valid  output  1  out_data holds an unconsumed result.
- out_data  output  4  signed block average.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- drop_cnt  output  8  saturating count of overwritten results.

Behaviour:
- Reset (rst=0, asynchronous):
  - acc=0, cnt=0, out_valid=0, out_data=0, drop_cnt=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst deasserts.
  - Reset mid-block discards the partial sum.
- Sample acceptance:
  - A sample is accepted on a clk edge when in_valid=1; in_valid=0 cycles are ignored (gaps allowed).
  - Each accepted sample is sign-extended to ACC_W and added to acc; cnt increments.
- Block completion, on the edge accepting sample cnt=DECIM-1:
  - sum = acc + sext(in_data).
  - result = sum >>> SHIFT (arithmetic shift, i.e. floor).
  - out_data <= result[3:0], out_valid <= 1.
  - acc <= 0, cnt <= 0.
  - Latency is 1 cycle: the result is visible the cycle after the last sample's edge.
- Range: the average of signed 4-bit values always lies in -8..7, so no saturation logic is needed.
- Handshake:
  - When out_valid=1 and out_ready=1 on an edge with no new completion, out_valid <= 0.
  - out_data holds its value while out_valid=0 (no clearing).
- Simultaneous events:
  - Completion with out_valid=0: load the result; no drop.
  - Completion with out_valid=1 and out_ready=1: the old result is consumed, the new one is loaded, out_valid stays 1, no drop.
  - Completion with out_valid=1 and out_ready=0: the new result overwrites out_data, out_valid stays 1, drop_cnt increments.
- drop_cnt saturates at 255 and clears only on reset.
- State view:
  - FILL (cnt 0..DECIM-1), with an independent output register flag out_valid.
  - No other states; cnt wraps DECIM-1 -> 0 only on completion.

Optional Feature:
- Macro: IIR_DECIM_ROUND_EN.
- Defined: result = (sum + 2**(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - Maximum is (7*DECIM + DECIM/2) >> SHIFT = 7, so no overflow.
- Undefined: floor (plain arithmetic shift).
- Handshake, latency and drop behaviour are identical in both builds.

Test Plan:
- SHIFT=2; samples 1,2,3,4 with in_valid continuous, out_ready=1 -> out_valid pulses one cycle after the 4th sample, out_data=2 (floor) or 3 (ROUND_EN); drop_cnt=0.
- Samples -1,-1,-1,-2 -> out_data=4'b1110 (-2) floor, 4'b1111 (-1) ROUND_EN.
- Extremes: four 7s -> 7; four -8s -> -8 (4'b1000) in both builds.
- out_ready=0; blocks {4,4,4,4} then {-4,-4,-4,-4} -> out_valid stays 1, out_data=-4, drop_cnt=1. Then raise out_ready for one cycle -> out_valid=0.
- Sample 5 twice, assert rst low mid-block, release, then feed 2,2,2,2 -> out_data=2, confirming the partial sum was discarded. During reset: out_valid=0, in_ready=0.
- in_valid toggled 1,0,1,0... with samples 3,3,3,3 and out_ready=1 -> result 3 arrives one cycle after the 4th valid sample. Completion coincident with out_ready=1 on a pending result -> no drop.
